// File: rtl/traffic_light_ctrl.sv
// Round-robin traffic light controller with optional pedestrian request (TRAFFIC_PED_REQ_EN).
// Lamps are decoded from registered state; a state change shows on the next cycle.
// hold freezes state, counter and dir; a pedestrian request is still captured while held.
module traffic_light_ctrl #(
    parameter int NUM_DIR       = 2,
    parameter int CNT_W         = 8,
    parameter int INIT_CYC      = 16,
    parameter int GREEN_CYC     = 64,
    parameter int MIN_GREEN_CYC = 16,
    parameter int YELLOW_CYC    = 8,
    parameter int ALLRED_CYC    = 4,
    parameter int PED_CYC       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               pass,
    output logic [NUM_DIR-1:0] R,
    output logic [NUM_DIR-1:0] G,
    output logic [NUM_DIR-1:0] Y,
    output logic               walk,
    output logic [1:0]         dir
);

    localparam logic [1:0] S_INIT   = 2'd0;
    localparam logic [1:0] S_GREEN  = 2'd1;
    localparam logic [1:0] S_YELLOW = 2'd2;
    localparam logic [1:0] S_ALLRED = 2'd3;

    localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_CYC - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] MING_LAST   = CNT_W'(MIN_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] PED_LAST    = CNT_W'(PED_CYC - 1);
    localparam logic [1:0]       DIR_LAST    = 2'(NUM_DIR - 1);
    localparam logic [NUM_DIR-1:0] DIR_ONE   = NUM_DIR'(1);

    logic [1:0]       state;
    logic [1:0]       nxt_state;
    logic [CNT_W-1:0] cnt;
    logic             ped_pend;
    logic             change;

    always_comb begin
        nxt_state = state;
        case (state)
            S_INIT:   if (cnt == INIT_LAST) nxt_state = S_GREEN;
            S_GREEN:  if (cnt == GREEN_LAST || (ped_pend && cnt >= MING_LAST))
                          nxt_state = S_YELLOW;
            S_YELLOW: if (cnt == YELLOW_LAST) nxt_state = S_ALLRED;
            // >= keeps the counter from running away if PED_CYC < ALLRED_CYC
            default:  if (cnt >= (ped_pend ? PED_LAST : ALLRED_LAST)) nxt_state = S_GREEN;
        endcase
    end

    assign change = nxt_state != state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
            cnt   <= '0;
            dir   <= 2'd0;
        end else if (!hold) begin
            state <= nxt_state;
            cnt   <= change ? '0 : cnt + 1'b1;
            if (change && state == S_ALLRED)
                dir <= (dir == DIR_LAST) ? 2'd0 : dir + 2'd1;
        end
    end

`ifdef TRAFFIC_PED_REQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ped_pend <= 1'b0;
        else if (pass)
            ped_pend <= 1'b1;
        else if (!hold && change && state == S_ALLRED)
            ped_pend <= 1'b0;
    end
`else
    logic unused_pass;
    assign unused_pass = pass;
    assign ped_pend    = 1'b0;
`endif

    always_comb begin
        G = '0;
        Y = '0;
        if (state == S_GREEN)  G = DIR_ONE << dir;
        if (state == S_YELLOW) Y = DIR_ONE << dir;
    end

    assign R    = ~(G | Y);
    assign walk = (state == S_ALLRED) && ped_pend;

endmodule
